// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_if.sv
// Control and status bundle for the programmable clock divider.
//   master : drives EN (run request), DIV (ratio), LD (load strobe);
//            observes Z (divided clock), TC (end-of-period pulse),
//            PEND (ratio waiting to apply), RUNNING (RUN or STOPPING).
//   slave  : the divider itself.
interface gf180mcu_fd_sc_mcu7t5v0__clkdiv_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic [WIDTH-1:0] DIV;
  logic             LD;
  logic             Z;
  logic             TC;
  logic             PEND;
  logic             RUNNING;

  modport master (output EN, DIV, LD, input Z, TC, PEND, RUNNING);
  modport slave  (input EN, DIV, LD, output Z, TC, PEND, RUNNING);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv.sv
// Programmable 50%-duty clock divider. Z is a flop output with period
// 2*(div_q+1) CLK cycles. Ratio reloads take effect only at the Z falling
// edge (or on the next edge while idle); stopping always completes the
// current Z period.
//   CLK  : source clock, all state on the rising edge
//   RN   : asynchronous active-low reset
//   bus  : slave side of the control/status interface (EN, DIV, LD in;
//          Z, TC, PEND, RUNNING out)
// Build option: define GF180MCU_FD_SC_MCU7T5V0_CLKDIV_SYNC_EN to pass EN
// through a two-flop synchroniser (EN timing then shifts by two cycles).
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | stopped, Z=0, cnt=0
// ST_RUN      | counting, EN requested
// ST_STOPPING | counting, EN dropped; returns to idle at next Z fall
module gf180mcu_fd_sc_mcu7t5v0__clkdiv #(
  parameter int WIDTH     = 4,
  parameter int RESET_DIV = 0
) (
  input logic                                      CLK,
  input logic                                      RN,
  gf180mcu_fd_sc_mcu7t5v0__clkdiv_if.slave         bus
);

  localparam logic [WIDTH-1:0] RESET_DIV_W = RESET_DIV[WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_flag_q, pend_flag_d;
  logic             z_q, z_d;
  logic             tc_q, tc_d;

  logic             en_s;
  logic             counting;
  logic             wrap;
  logic             z_fall;
  logic             apply_edge;

`ifdef GF180MCU_FD_SC_MCU7T5V0_CLKDIV_SYNC_EN
  logic en_meta_q, en_sync_q;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      en_meta_q <= bus.EN;
      en_sync_q <= en_meta_q;
    end
  end

  assign en_s = en_sync_q;
`else
  assign en_s = bus.EN;
`endif

  assign counting = (state_q != ST_IDLE);
  assign wrap     = (cnt_q == div_q);
  assign z_fall   = counting && wrap && z_q;
  // Period boundary while counting; while idle any pending ratio applies
  // on the next edge since no period is in progress.
  assign apply_edge = z_fall || ((state_q == ST_IDLE) && pend_flag_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    tc_d        = 1'b0;
    div_d       = div_q;
    pend_div_d  = pend_div_q;
    pend_flag_d = pend_flag_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        z_d   = 1'b0;
        if (en_s) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_s) state_d = ST_STOPPING;
      end
      ST_STOPPING: begin
        // A re-request wins over the stop so the clock continues seamlessly.
        if (en_s)        state_d = ST_RUN;
        else if (z_fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (counting) begin
      if (wrap) begin
        cnt_d = '0;
        z_d   = ~z_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end

    tc_d = z_fall;

    if (apply_edge && bus.LD) begin
      div_d       = bus.DIV;
      pend_flag_d = 1'b0;
    end else if (apply_edge && pend_flag_q) begin
      div_d       = pend_div_q;
      pend_flag_d = 1'b0;
    end else if (bus.LD) begin
      pend_div_d  = bus.DIV;
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      z_q         <= 1'b0;
      tc_q        <= 1'b0;
      div_q       <= RESET_DIV_W;
      pend_div_q  <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      z_q         <= z_d;
      tc_q        <= tc_d;
      div_q       <= div_d;
      pend_div_q  <= pend_div_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  assign bus.Z       = z_q;
  assign bus.TC      = tc_q;
  assign bus.PEND    = pend_flag_q;
  assign bus.RUNNING = counting;

endmodule
